// File: rtl/mux_nbit_nto1_reg.sv
// CHANNELS:1 word mux with a one-entry registered output buffer and valid/ready
// handshakes. Selection is either directed by Sel or round-robin over valid requesters.
module mux_nbit_nto1_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] In_Data,
  input  logic [CHANNELS-1:0]       In_Valid,
  output logic [CHANNELS-1:0]       In_Ready,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          Sel,
  output logic [WIDTH-1:0]          Out_Data,
  output logic [SEL_W-1:0]          Out_Chan,
  output logic                      Out_Valid,
  input  logic                      Out_Ready
);

  logic [CHANNELS-1:0][WIDTH-1:0] words;
  logic [CHANNELS-1:0]            grant;
  logic [SEL_W-1:0]               gidx;
  logic                           gvld;
  logic [SEL_W-1:0]               rr_ptr;
  logic [SEL_W-1:0]               rr_next;
  logic                           load;
  int                             idx;

  // Flat bus already has channel i at [i*WIDTH +: WIDTH], matching the packed layout.
  assign words = In_Data;

  assign load = ~Out_Valid | Out_Ready;

  always_comb begin
    grant = '0;
    gidx  = '0;
    gvld  = 1'b0;
    idx   = 0;
    if (!Mode) begin
      // Out-of-range Sel simply matches no channel.
      for (int i = 0; i < CHANNELS; i++) begin
        if (int'(Sel) == i && In_Valid[i]) begin
          grant[i] = 1'b1;
          gidx     = SEL_W'(i);
          gvld     = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!gvld && In_Valid[idx]) begin
          grant[idx] = 1'b1;
          gidx       = SEL_W'(idx);
          gvld       = 1'b1;
        end
      end
    end
  end

  assign In_Ready = Reset ? '0 : (grant & {CHANNELS{load}});
  assign rr_next  = (int'(gidx) == CHANNELS - 1) ? '0 : gidx + 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Out_Chan  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      // Empty or draining: take the granted word, or go empty holding the last data.
      Out_Valid <= gvld;
      if (gvld) begin
        Out_Data <= words[gidx];
        Out_Chan <= gidx;
        if (Mode) rr_ptr <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_mux_nbit_nto1_reg.sv
// Directed bench for mux_nbit_nto1_reg: default 16x4 instance plus 8x2 and 16x3 variants.
module tb_mux_nbit_nto1_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=16, CHANNELS=4
  logic [15:0] wa [4];
  logic [63:0] a_data;
  logic [3:0]  a_valid, a_ready;
  logic        a_mode, a_oready, a_ovalid;
  logic [1:0]  a_sel, a_chan;
  logic [15:0] a_odata;
  assign a_data = {wa[3], wa[2], wa[1], wa[0]};

  mux_nbit_nto1_reg #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) dut_a (
    .Clk(clk), .Reset(rst), .In_Data(a_data), .In_Valid(a_valid), .In_Ready(a_ready),
    .Mode(a_mode), .Sel(a_sel), .Out_Data(a_odata), .Out_Chan(a_chan),
    .Out_Valid(a_ovalid), .Out_Ready(a_oready));

  // Instance B: WIDTH=8, CHANNELS=2, SEL_W=1
  logic [15:0] b_data;
  logic [1:0]  b_valid, b_ready;
  logic        b_mode, b_sel, b_chan, b_oready, b_ovalid;
  logic [7:0]  b_odata;

  mux_nbit_nto1_reg #(.WIDTH(8), .CHANNELS(2), .SEL_W(1)) dut_b (
    .Clk(clk), .Reset(rst), .In_Data(b_data), .In_Valid(b_valid), .In_Ready(b_ready),
    .Mode(b_mode), .Sel(b_sel), .Out_Data(b_odata), .Out_Chan(b_chan),
    .Out_Valid(b_ovalid), .Out_Ready(b_oready));

  // Instance C: WIDTH=16, CHANNELS=3, SEL_W=2
  logic [47:0] c_data;
  logic [2:0]  c_valid, c_ready;
  logic        c_mode, c_oready, c_ovalid;
  logic [1:0]  c_sel, c_chan;
  logic [15:0] c_odata;

  mux_nbit_nto1_reg #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) dut_c (
    .Clk(clk), .Reset(rst), .In_Data(c_data), .In_Valid(c_valid), .In_Ready(c_ready),
    .Mode(c_mode), .Sel(c_sel), .Out_Data(c_odata), .Out_Chan(c_chan),
    .Out_Valid(c_ovalid), .Out_Ready(c_oready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_a(input string tag, input int chan, input logic [15:0] data);
    @(posedge clk); #1;
    chk({tag, " valid"}, 32'(a_ovalid), 1);
    chk({tag, " chan"},  32'(a_chan), 32'(chan));
    chk({tag, " data"},  32'(a_odata), 32'(data));
  endtask

  initial begin
    rst = 1'b1;
    wa[0] = 16'h1111; wa[1] = 16'h2222; wa[2] = 16'hBEEF; wa[3] = 16'h4444;
    a_valid = 4'b1111; a_mode = 1'b0; a_sel = 2'd2; a_oready = 1'b1;
    b_data = '0; b_valid = '0; b_mode = 1'b0; b_sel = 1'b0; b_oready = 1'b1;
    c_data = '0; c_valid = '0; c_mode = 1'b0; c_sel = '0; c_oready = 1'b1;

    // Reset state: inputs valid but In_Ready held low
    #2;
    chk("rst valid", 32'(a_ovalid), 0);
    chk("rst data",  32'(a_odata), 0);
    chk("rst chan",  32'(a_chan), 0);
    chk("rst in_ready", 32'(a_ready), 0);
    @(posedge clk); #1; rst = 1'b0;

    // Directed select of ch2
    #1 chk("dir in_ready", 32'(a_ready), 32'b0100);
    edge_a("dir xfer", 2, 16'hBEEF);
    a_valid = 4'b1011;
    #1 chk("dir nogrant in_ready", 32'(a_ready), 0);
    @(posedge clk); #1;
    chk("dir drain valid", 32'(a_ovalid), 0);
    chk("dir drain data hold", 32'(a_odata), 32'hBEEF);
    chk("dir drain chan hold", 32'(a_chan), 2);

    // Round-robin over all four: 0,1,2,3,0,1
    a_mode = 1'b1; a_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr in_ready", 32'(a_ready), 32'(1 << (i % 4)));
      edge_a("rr xfer", i % 4, wa[i % 4]);
    end
    // rr_ptr=2, only ch0 and ch3 requesting -> ch3 then ch0
    a_valid = 4'b1001;
    #1 chk("rr sparse ready3", 32'(a_ready), 32'b1000);
    edge_a("rr sparse 3", 3, 16'h4444);
    #1 chk("rr sparse ready0", 32'(a_ready), 32'b0001);
    edge_a("rr sparse 0", 0, 16'h1111);

    // Backpressure: holding ch0 word, rr_ptr=1
    a_oready = 1'b0; a_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp in_ready", 32'(a_ready), 0);
      edge_a("bp hold", 0, 16'h1111);
    end
    a_oready = 1'b1;
    #1 chk("bp release ready", 32'(a_ready), 32'b0010);
    edge_a("bp refill", 1, 16'h2222);

    // Mode switch: advance to rr_ptr=3, two directed transfers, back to round-robin
    edge_a("ms rr2", 2, 16'hBEEF);
    a_mode = 1'b0; a_sel = 2'd1;
    #1 chk("ms dir ready", 32'(a_ready), 32'b0010);
    edge_a("ms dir1", 1, 16'h2222);
    wa[1] = 16'h5555;
    edge_a("ms dir2", 1, 16'h5555);
    a_mode = 1'b1;
    #1 chk("ms rr ready", 32'(a_ready), 32'b1000);
    edge_a("ms rr3", 3, 16'h4444);

    // Reset mid-cycle with a buffered word, then rr_ptr back at 0
    #2 rst = 1'b1;
    #1;
    chk("mid rst valid", 32'(a_ovalid), 0);
    chk("mid rst data",  32'(a_odata), 0);
    chk("mid rst chan",  32'(a_chan), 0);
    chk("mid rst in_ready", 32'(a_ready), 0);
    @(posedge clk); #1; rst = 1'b0;
    #1 chk("post rst rr ready", 32'(a_ready), 32'b0001);
    edge_a("post rst xfer", 0, 16'h1111);
    a_valid = 4'b0000;

    // WIDTH=8, CHANNELS=2
    b_data = {8'hB2, 8'hA1}; b_valid = 2'b11; b_sel = 1'b1;
    #1 chk("b dir ready", 32'(b_ready), 32'b10);
    @(posedge clk); #1;
    chk("b dir data", 32'(b_odata), 32'hB2);
    chk("b dir chan", 32'(b_chan), 1);
    b_mode = 1'b1;
    @(posedge clk); #1;
    chk("b rr0", 32'(b_chan), 0);
    chk("b rr0 data", 32'(b_odata), 32'hA1);
    @(posedge clk); #1;
    chk("b rr1", 32'(b_chan), 1);
    @(posedge clk); #1;
    chk("b rr wrap", 32'(b_chan), 0);
    b_valid = 2'b00;

    // WIDTH=16, CHANNELS=3: Sel=3 is out of range
    c_data = {16'hC002, 16'hC001, 16'hC000}; c_valid = 3'b111; c_sel = 2'd3;
    #1 chk("c sel3 ready", 32'(c_ready), 0);
    @(posedge clk); #1;
    chk("c sel3 valid", 32'(c_ovalid), 0);
    c_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("c rr ready", 32'(c_ready), 32'(1 << (i % 3)));
      @(posedge clk); #1;
      chk("c rr chan", 32'(c_chan), 32'(i % 3));
      chk("c rr data", 32'(c_odata), 32'(16'hC000 + 16'(i % 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_nbit_nto1_reg.md
Name: mux_nbit_nto1_reg

Overview:
- Parametrised successor of the 2:1 word muxes: selects one of CHANNELS input words, each WIDTH bits wide, into a registered output stage with valid/ready handshakes.
- Two selection modes: directed (external Sel, as the datapath operand/result muxes use it) and round-robin arbitration among valid requesters (shared bus/writeback port).
- Sits between producer units and a single consumer in the 16-bit processor datapath.

Parameters:
WIDTH, 16, bits per data word
CHANNELS, 4, number of input channels (>=2)
SEL_W, 2, select/channel-index width; must satisfy 2**SEL_W >= CHANNELS

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
In_Data  input  CHANNELS*WIDTH  packed input words; channel i at [i*WIDTH +: WIDTH]
In_Valid  input  CHANNELS  per-channel word valid
In_Ready  output  CHANNELS  per-channel accept; combinational
Mode  input  1  0 = directed by Sel, 1 = round-robin
Sel  input  SEL_W  channel index used in directed mode
Out_Data  output  WIDTH  registered selected word
Out_Chan  output  SEL_W  registered index of the channel that supplied Out_Data
Out_Valid  output  1  Out_Data/Out_Chan hold a word
Out_Ready  input  1  consumer accepts the word this cycle

Behaviour:
- One clock (Clk); Reset is asynchronous and active-high. While asserted, and immediately on assertion: Out_Valid=0, Out_Data=0, Out_Chan=0, rr_ptr=0. In_Ready is all-zero while Reset is high.
- Output register is a one-entry buffer. load = ~Out_Valid | Out_Ready. Throughput: one word per cycle with Out_Ready held high.
- Grant (combinational, at most one bit set):
  - Mode=0: grant[Sel] = In_Valid[Sel]. A Sel value >= CHANNELS yields no grant.
  - Mode=1: grant the first valid channel found scanning from index rr_ptr upward, wrapping from CHANNELS-1 to 0. No valid channel yields no grant.
- In_Ready[i] = grant[i] & load. Transfer on input i occurs when In_Valid[i] & In_Ready[i].
- On a transfer from channel g at a rising edge: Out_Data<=word g, Out_Chan<=g, Out_Valid<=1. Latency from input transfer to Out_Valid is 1 cycle.
- If load=1 and there is no grant: Out_Valid<=0 (the word is drained if Out_Ready=1). Out_Data and Out_Chan hold their last values.
- If Out_Valid=1 and Out_Ready=0: all outputs hold and no input is accepted (backpressure).
- Simultaneous drain and refill (Out_Valid=1, Out_Ready=1, grant present): the new word replaces the old one in the same edge with no bubble.
- rr_ptr updates only on a transfer while Mode=1: rr_ptr<=(g+1) mod CHANNELS, so CHANNELS-1 wraps to 0. A Mode=0 transfer leaves rr_ptr unchanged.
- Mode or Sel changes take effect on the next arbitration. A word already registered is unaffected.
- Reset asserted mid-operation discards the buffered word. No transfer is reported for the cycle in which Reset is asserted.
- The output register has no combinational path from In_* to Out_*.

Test Plan:
- Reset: assert Reset mid-cycle with Out_Valid=1 -> Out_Valid=0, Out_Data=0x0000, Out_Chan=0 immediately; In_Ready=4'b0000.
- Directed: Mode=0, Sel=2, In_Valid=4'b1111, ch2=0xBEEF, Out_Ready=1 -> In_Ready=4'b0100; next cycle Out_Data=0xBEEF, Out_Chan=2, Out_Valid=1. Then Sel=2, In_Valid=4'b1011 -> no grant; Out_Valid drops to 0 after the drain.
- Round-robin fairness and wrap: Mode=1, all 4 valid, Out_Ready=1 for 6 cycles -> Out_Chan sequence 0,1,2,3,0,1. Then only ch0 and ch3 valid with rr_ptr=2 -> ch3 granted, then ch0.
- Backpressure: Out_Valid=1, Out_Ready=0 for 3 cycles with new inputs valid -> Out_Data/Out_Chan stable, In_Ready=0. Then Out_Ready=1 -> the buffered word is consumed and the next word loads on the same edge.
- Mode switch: run Mode=1 to rr_ptr=3, switch to Mode=0 with Sel=1 for 2 transfers, return to Mode=1 -> rr_ptr still 3, so ch3 is granted first.
- Parameter sweep: WIDTH=8 with CHANNELS=2, and WIDTH=16 with CHANNELS=3 and SEL_W=2 -> Sel=3 gives no grant; round-robin wraps 2->0.
